// File: rtl/alu_ctrl_unit_pkg.sv
// Shared definitions for the RV32I ALU-control decode stage and the execute-stage ALU.
// Holds the ALU control encodings, the opcode/funct constants, the decoded control
// bundle carried through the output stage, and a funct3 -> ALU op helper.
package alu_ctrl_unit_pkg;

    localparam int unsigned XLEN_C = 32;
    localparam int unsigned REG_W  = 5;

    // ALU control word seen by the execute stage
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLTU = 4'b0101,
        ALU_NONE = 4'b1111
    } alu_op_e;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // funct3 values
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;
    localparam logic [2:0] F3_JALR    = 3'b000;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_SUB  = 7'h20;

    // Decoded control bundle
    typedef struct packed {
        alu_op_e           alu_ctrl;
        logic              alu_src;
        logic [XLEN_C-1:0] imm;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              branch_inv;
        logic              illegal;
    } dec_t;

    localparam dec_t DEC_RESET = '{
        alu_ctrl:   ALU_NONE,
        alu_src:    1'b0,
        imm:        '0,
        rs1:        '0,
        rs2:        '0,
        rd:         '0,
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        branch:     1'b0,
        branch_inv: 1'b0,
        illegal:    1'b0
    };

    // Arithmetic funct3 shared by OP and OP-IMM; shifts and signed compare are unsupported
    function automatic alu_op_e f3_to_alu(input logic [2:0] f3);
        case (f3)
            F3_ADD_SUB: f3_to_alu = ALU_ADD;
            F3_SLTU:    f3_to_alu = ALU_SLTU;
            F3_XOR:     f3_to_alu = ALU_XOR;
            F3_OR:      f3_to_alu = ALU_OR;
            F3_AND:     f3_to_alu = ALU_AND;
            default:    f3_to_alu = ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I decoder: instruction word -> ALU control bundle.
// Ports:
//   instr_i  in  32  instruction word
//   dec_o    out     decoded control bundle (dec_t), combinational
module alu_ctrl_decode
    import alu_ctrl_unit_pkg::*;
(
    input  logic [XLEN_C-1:0] instr_i,
    output dec_t              dec_o
);

    logic [6:0]        opcode;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [XLEN_C-1:0] imm_i;
    logic [XLEN_C-1:0] imm_s;
    logic [XLEN_C-1:0] imm_b;
    logic [XLEN_C-1:0] imm_u;
    logic [XLEN_C-1:0] imm_j;
    logic              legal;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    // Immediates; instr[31] is the sign in every format
    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};

    // Register fields are only driven for formats that actually carry them
    always_comb begin
        dec_o          = DEC_RESET;
        dec_o.alu_ctrl = ALU_ADD;
        legal          = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec_o.rs1       = instr_i[19:15];
                dec_o.rs2       = instr_i[24:20];
                dec_o.rd        = instr_i[11:7];
                dec_o.reg_write = 1'b1;
                if (f7 == F7_SUB && f3 == F3_ADD_SUB) begin
                    dec_o.alu_ctrl = ALU_SUB;
                end else if (f7 == F7_BASE) begin
                    dec_o.alu_ctrl = f3_to_alu(f3);
                end else begin
                    dec_o.alu_ctrl = ALU_NONE;
                end
                legal = (dec_o.alu_ctrl != ALU_NONE);
            end
            OPC_OP_IMM: begin
                dec_o.rs1       = instr_i[19:15];
                dec_o.rd        = instr_i[11:7];
                dec_o.imm       = imm_i;
                dec_o.alu_src   = 1'b1;
                dec_o.reg_write = 1'b1;
                dec_o.alu_ctrl  = f3_to_alu(f3);
                legal           = (dec_o.alu_ctrl != ALU_NONE);
            end
            OPC_LOAD: begin
                dec_o.rs1       = instr_i[19:15];
                dec_o.rd        = instr_i[11:7];
                dec_o.imm       = imm_i;
                dec_o.alu_src   = 1'b1;
                dec_o.reg_write = 1'b1;
                dec_o.mem_read  = 1'b1;
                legal           = (f3 == F3_LW);
            end
            OPC_STORE: begin
                dec_o.rs1       = instr_i[19:15];
                dec_o.rs2       = instr_i[24:20];
                dec_o.imm       = imm_s;
                dec_o.alu_src   = 1'b1;
                dec_o.mem_write = 1'b1;
                legal           = (f3 == F3_SW);
            end
            OPC_BRANCH: begin
                dec_o.rs1    = instr_i[19:15];
                dec_o.rs2    = instr_i[24:20];
                dec_o.imm    = imm_b;
                dec_o.branch = 1'b1;
                case (f3)
                    F3_BEQ:  dec_o.alu_ctrl = ALU_SUB;
                    F3_BNE:  begin
                        dec_o.alu_ctrl   = ALU_SUB;
                        dec_o.branch_inv = 1'b1;
                    end
                    F3_BLTU: dec_o.alu_ctrl = ALU_SLTU;
                    F3_BGEU: begin
                        dec_o.alu_ctrl   = ALU_SLTU;
                        dec_o.branch_inv = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                // rs1 stays 0 so the ALU computes x0 + imm
                dec_o.rd        = instr_i[11:7];
                dec_o.imm       = imm_u;
                dec_o.alu_src   = 1'b1;
                dec_o.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec_o.rd        = instr_i[11:7];
                dec_o.imm       = imm_u;
                dec_o.alu_src   = 1'b1;
                dec_o.reg_write = 1'b1;
            end
            OPC_JAL: begin
                dec_o.rd        = instr_i[11:7];
                dec_o.imm       = imm_j;
                dec_o.alu_src   = 1'b1;
                dec_o.reg_write = 1'b1;
            end
            OPC_JALR: begin
                dec_o.rs1       = instr_i[19:15];
                dec_o.rd        = instr_i[11:7];
                dec_o.imm       = imm_i;
                dec_o.alu_src   = 1'b1;
                dec_o.reg_write = 1'b1;
                legal           = (f3 == F3_JALR);
            end
            default: legal = 1'b0;
        endcase

        // Anything the ALU cannot execute must have no side effects downstream
        if (!legal) begin
            dec_o.alu_ctrl   = ALU_NONE;
            dec_o.reg_write  = 1'b0;
            dec_o.mem_read   = 1'b0;
            dec_o.mem_write  = 1'b0;
            dec_o.branch     = 1'b0;
            dec_o.branch_inv = 1'b0;
            dec_o.illegal    = 1'b1;
        end
    end

endmodule

// File: rtl/alu_ctrl_unit.sv
// RV32I ALU-control decode stage with a registered output slot and one skid slot.
// Ports:
//   clk, rstN (sync, active-low)
//   inValid/inReady/instr       instruction input handshake
//   flush                       drop every buffered entry
//   outValid/outReady           decoded-entry output handshake
//   aluCtrl, aluSrc, imm, rs1, rs2, rd, regWrite, memRead, memWrite,
//   branch, branchInv, illegal  registered decoded fields
module alu_ctrl_unit
    import alu_ctrl_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            inValid,
    output logic            inReady,
    input  logic [XLEN-1:0] instr,
    input  logic            flush,
    output logic            outValid,
    input  logic            outReady,
    output logic [3:0]      aluCtrl,
    output logic            aluSrc,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            regWrite,
    output logic            memRead,
    output logic            memWrite,
    output logic            branch,
    output logic            branchInv,
    output logic            illegal
);

    dec_t dec;
    dec_t out_q, out_d;
    dec_t skid_q, skid_d;
    logic out_valid_q, out_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic in_ready_q, in_ready_d;
    logic accept;
    logic drain;

    alu_ctrl_decode u_decode (
        .instr_i (instr),
        .dec_o   (dec)
    );

    assign accept = inValid && in_ready_q;
    assign drain  = out_valid_q && outReady;

    // Next state; skid is only ever occupied while the output slot is occupied
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rstN) begin
            out_q        <= DEC_RESET;
            skid_q       <= DEC_RESET;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign inReady   = in_ready_q;
    assign outValid  = out_valid_q;
    assign aluCtrl   = out_q.alu_ctrl;
    assign aluSrc    = out_q.alu_src;
    assign imm       = out_q.imm;
    assign rs1       = out_q.rs1;
    assign rs2       = out_q.rs2;
    assign rd        = out_q.rd;
    assign regWrite  = out_q.reg_write;
    assign memRead   = out_q.mem_read;
    assign memWrite  = out_q.mem_write;
    assign branch    = out_q.branch;
    assign branchInv = out_q.branch_inv;
    assign illegal   = out_q.illegal;

endmodule
